// File: rtl/tdc_stream_pkg.sv
// Shared types and constants for the TDC transmit stream.
package tdc_stream_pkg;

    localparam int unsigned DW        = 15;
    localparam int unsigned IW        = 4;
    localparam int unsigned MAX_HITS  = 3;
    localparam int unsigned FINE_BITS = 4;
    localparam int unsigned CW        = DW - FINE_BITS;
    localparam int unsigned HW        = DW + IW;

    localparam logic [DW-1:0] NOHIT = 15'h7FFF;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StSend
    } state_e;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] inten;
    } hit_t;

endpackage

// File: rtl/tdc_hit_buf.sv
// Three-entry hit buffer; arrival order by default, ascending timestamp order
// when TDC_TX_SORT_EN is defined. Reads see the next-state contents.
module tdc_hit_buf
    import tdc_stream_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic [HW-1:0] push_hit_i,
    input  logic [1:0]    rd_idx_i,
    output logic [1:0]    count_o,
    output logic [1:0]    nxt_count_o,
    output logic          full_o,
    output logic [HW-1:0] nxt_rd_o
);

    hit_t       entries_q [MAX_HITS];
    hit_t       entries_d [MAX_HITS];
    logic [1:0] count_q, count_d;
    hit_t       new_hit;

`ifdef TDC_TX_SORT_EN
    logic [1:0] pos;
`endif

    assign new_hit = push_hit_i;
    assign full_o  = (count_q == 2'(MAX_HITS));

    always_comb begin
        count_d   = count_q;
        entries_d = entries_q;
`ifdef TDC_TX_SORT_EN
        pos = 2'd0;
`endif
        if (clr_i) begin
            count_d = 2'd0;
        end else if (push_i && !full_o) begin
`ifdef TDC_TX_SORT_EN
            // Insert after every entry with an equal or smaller timestamp.
            for (int i = 0; i < MAX_HITS; i++) begin
                if (2'(i) < count_q && entries_q[i].data <= new_hit.data) begin
                    pos = pos + 2'd1;
                end
            end
            for (int i = MAX_HITS - 1; i >= 1; i--) begin
                if (2'(i) > pos && 2'(i) <= count_q) begin
                    entries_d[i] = entries_q[i-1];
                end
            end
            entries_d[pos] = new_hit;
`else
            entries_d[count_q] = new_hit;
`endif
            count_d = count_q + 2'd1;
        end
    end

    always_comb begin
        case (rd_idx_i)
            2'd1:    nxt_rd_o = entries_d[1];
            2'd2:    nxt_rd_o = entries_d[2];
            default: nxt_rd_o = entries_d[0];
        endcase
    end

    assign count_o     = count_q;
    assign nxt_count_o = count_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q   <= 2'd0;
            entries_q <= '{default: '0};
        end else begin
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

endmodule

// File: rtl/tdc_stream_tx.sv
// TDC transmit stream: collects hits over one measurement window, then bursts them
// out as ready/valid beats. Define TDC_TX_SORT_EN for timestamp-ordered output.
module tdc_stream_tx
    import tdc_stream_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          TDC_start,
    input  logic [DW-1:0] TDC_Range,
    input  logic          hit_valid,
    input  logic [DW-1:0] hit_data,
    input  logic [IW-1:0] hit_int,
    output logic [DW-1:0] TDC_Odata,
    output logic [IW-1:0] TDC_Oint,
    output logic [1:0]    TDC_Onum,
    output logic          TDC_Olast,
    output logic          TDC_Ovalid,
    input  logic          TDC_Oready,
    output logic          hit_drop
);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, limit;
    logic          pending_q, pending_d;
    logic [1:0]    beat_q, beat_d;
    logic [DW-1:0] odata_q, odata_d;
    logic [IW-1:0] oint_q, oint_d;
    logic [1:0]    onum_q, onum_d;
    logic          olast_q, olast_d, ovalid_q, ovalid_d, drop_q, drop_d;

    logic          clr, push, full, timeout, xfer, load;
    logic [1:0]    rd_idx, count, nxt_count;
    logic [HW-1:0] rd_raw;
    hit_t          rd_hit;

    assign limit   = TDC_Range[DW-1:FINE_BITS];
    assign timeout = (limit == '0) || (cnt_q + 1'b1 == limit);
    assign xfer    = ovalid_q && TDC_Oready;
    assign rd_hit  = rd_raw;
    assign push    = (state_q == StCollect) && hit_valid && !full;
    assign rd_idx  = (state_q == StSend) ? beat_q + 2'd1 : 2'd0;

    tdc_hit_buf u_buf (
        .clk_i       (clk),
        .rst_i       (rst),
        .clr_i       (clr),
        .push_i      (push),
        .push_hit_i  ({hit_data, hit_int}),
        .rd_idx_i    (rd_idx),
        .count_o     (count),
        .nxt_count_o (nxt_count),
        .full_o      (full),
        .nxt_rd_o    (rd_raw)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        beat_d    = beat_q;
        odata_d   = odata_q;
        oint_d    = oint_q;
        onum_d    = onum_q;
        olast_d   = olast_q;
        ovalid_d  = ovalid_q;
        drop_d    = drop_q;
        clr       = 1'b0;
        load      = 1'b0;

        if ((state_q == StCollect) && hit_valid && full) begin
            drop_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (TDC_start || pending_q) begin
                    state_d   = StCollect;
                    cnt_d     = '0;
                    pending_d = 1'b0;
                    clr       = 1'b1;
                end
            end
            StCollect: begin
                cnt_d = cnt_q + 1'b1;
                if (TDC_start || timeout) begin
                    state_d = StSend;
                    beat_d  = 2'd0;
                    load    = 1'b1;
                    if (TDC_start) begin
                        pending_d = 1'b1;
                    end
                end
            end
            StSend: begin
                if (TDC_start) begin
                    pending_d = 1'b1;
                end
                if (xfer) begin
                    if (olast_q) begin
                        ovalid_d = 1'b0;
                        // A queued start restarts collection with no idle bubble.
                        if (pending_q || TDC_start) begin
                            state_d   = StCollect;
                            cnt_d     = '0;
                            pending_d = 1'b0;
                            clr       = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        beat_d = beat_q + 2'd1;
                        load   = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Buffer reads reflect a push in this same cycle, so the first beat is exact.
        if (load) begin
            ovalid_d = 1'b1;
            if (nxt_count == 2'd0) begin
                odata_d = NOHIT;
                oint_d  = '0;
                onum_d  = 2'd0;
                olast_d = 1'b1;
            end else begin
                odata_d = rd_hit.data;
                oint_d  = rd_hit.inten;
                onum_d  = nxt_count;
                olast_d = (rd_idx + 2'd1 == nxt_count);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            beat_q    <= 2'd0;
            odata_q   <= '0;
            oint_q    <= '0;
            onum_q    <= 2'd0;
            olast_q   <= 1'b0;
            ovalid_q  <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            beat_q    <= beat_d;
            odata_q   <= odata_d;
            oint_q    <= oint_d;
            onum_q    <= onum_d;
            olast_q   <= olast_d;
            ovalid_q  <= ovalid_d;
            drop_q    <= drop_d;
        end
    end

    assign TDC_Odata  = odata_q;
    assign TDC_Oint   = oint_q;
    assign TDC_Onum   = onum_q;
    assign TDC_Olast  = olast_q;
    assign TDC_Ovalid = ovalid_q;
    assign hit_drop   = drop_q;

endmodule

// File: tb/tb_tdc_stream_tx.sv
// Bench for tdc_stream_tx: frame-level reference model, directed and random frames.
module tb_tdc_stream_tx;

    logic        clk = 1'b0;
    logic        rst, TDC_start, hit_valid, TDC_Oready;
    logic [14:0] TDC_Range, hit_data;
    logic [3:0]  hit_int;
    logic [14:0] TDC_Odata;
    logic [3:0]  TDC_Oint;
    logic [1:0]  TDC_Onum;
    logic        TDC_Olast, TDC_Ovalid, hit_drop;

    always #2 clk = ~clk;

    tdc_stream_tx dut (
        .clk        (clk),
        .rst        (rst),
        .TDC_start  (TDC_start),
        .TDC_Range  (TDC_Range),
        .hit_valid  (hit_valid),
        .hit_data   (hit_data),
        .hit_int    (hit_int),
        .TDC_Odata  (TDC_Odata),
        .TDC_Oint   (TDC_Oint),
        .TDC_Onum   (TDC_Onum),
        .TDC_Olast  (TDC_Olast),
        .TDC_Ovalid (TDC_Ovalid),
        .TDC_Oready (TDC_Oready),
        .hit_drop   (hit_drop)
    );

    typedef struct {
        logic [14:0] d;
        logic [3:0]  i;
    } tb_hit_t;

    int checks   = 0;
    int failures = 0;

    // Frame plan, set by the caller before each frame.
    int          limit;
    int          plan_cyc[$];
    logic [14:0] plan_d[$];
    logic [3:0]  plan_i[$];
    int          early_at, send_start_obs, rst_at_obs;
    bit          rdy_pat[$];
    bit          rdy_always;

    // Model state.
    bit          pending;
    bit          exp_drop;
    bit          did_reset;
    tb_hit_t     cap[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_plan();
        plan_cyc.delete();
        plan_d.delete();
        plan_i.delete();
        rdy_pat.delete();
        early_at       = -1;
        send_start_obs = -1;
        rst_at_obs     = -1;
        rdy_always     = 1'b1;
    endtask

    task automatic add_hit(input int c, input logic [14:0] d, input logic [3:0] i);
        plan_cyc.push_back(c);
        plan_d.push_back(d);
        plan_i.push_back(i);
    endtask

    task automatic set_limit(input int l);
        logic [3:0] fine;
        limit     = l;
        fine      = 4'($urandom_range(0, 15));
        TDC_Range = {11'(l), fine};
    endtask

    task automatic do_collect();
        int w;
        int n;
        w = (limit == 0) ? 1 : limit;
        n = (early_at >= 0 && early_at < w) ? early_at + 1 : w;
        cap.delete();
        pending = 1'b0;
        for (int c = 0; c < n; c++) begin
            check_eq("collect_ovalid", 32'(TDC_Ovalid), 32'd0);
            for (int p = 0; p < plan_cyc.size(); p++) begin
                if (plan_cyc[p] == c) begin
                    hit_valid = 1'b1;
                    hit_data  = plan_d[p];
                    hit_int   = plan_i[p];
                    if (cap.size() < 3) cap.push_back('{plan_d[p], plan_i[p]});
                    else exp_drop = 1'b1;
                end
            end
            if (c == early_at) begin
                TDC_start = 1'b1;
                pending   = 1'b1;
            end
            tick();
            hit_valid = 1'b0;
            TDC_start = 1'b0;
        end
    endtask

    task automatic do_send();
        tb_hit_t exp[$];
        tb_hit_t src[$];
        int      nb, k, obs, best;
        bit      rdy;
        src = cap;
`ifdef TDC_TX_SORT_EN
        while (src.size() > 0) begin
            best = 0;
            for (int j = 1; j < src.size(); j++) if (src[j].d < src[best].d) best = j;
            exp.push_back(src[best]);
            src.delete(best);
        end
`else
        exp = src;
`endif
        nb        = (cap.size() == 0) ? 1 : cap.size();
        k         = 0;
        obs       = 0;
        did_reset = 1'b0;
        while (k < nb) begin
            if (obs >= 300) begin
                check_eq("send_timeout_beats", 32'(k), 32'(nb));
                break;
            end
            check_eq("ovalid", 32'(TDC_Ovalid), 32'd1);
            check_eq("odata", 32'(TDC_Odata), (cap.size() == 0) ? 32'h7FFF : 32'(exp[k].d));
            check_eq("oint", 32'(TDC_Oint), (cap.size() == 0) ? 32'd0 : 32'(exp[k].i));
            check_eq("onum", 32'(TDC_Onum), 32'(cap.size()));
            check_eq("olast", 32'(TDC_Olast), (k == nb - 1) ? 32'd1 : 32'd0);
            if (obs == rst_at_obs) begin
                rst = 1'b1;
                tick();
                rst       = 1'b0;
                did_reset = 1'b1;
                pending   = 1'b0;
                exp_drop  = 1'b0;
                return;
            end
            if (rdy_pat.size() > 0) rdy = rdy_pat.pop_front();
            else if (rdy_always) rdy = 1'b1;
            else rdy = ($urandom_range(0, 9) < 7);
            TDC_Oready = rdy;
            if (obs == send_start_obs) begin
                TDC_start = 1'b1;
                pending   = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) begin
                hit_valid = 1'b1;
                hit_data  = 15'($urandom);
                hit_int   = 4'($urandom);
            end
            tick();
            TDC_start  = 1'b0;
            hit_valid  = 1'b0;
            TDC_Oready = 1'b0;
            if (rdy) k++;
            obs++;
        end
        check_eq("after_burst_ovalid", 32'(TDC_Ovalid), 32'd0);
        check_eq("hit_drop", 32'(hit_drop), 32'(exp_drop));
    endtask

    task automatic run_frame();
        if (!pending) begin
            TDC_start = 1'b1;
            hit_valid = 1'b1;
            hit_data  = 15'($urandom);
            tick();
            TDC_start = 1'b0;
            hit_valid = 1'b0;
        end
        do_collect();
        do_send();
    endtask

    initial begin
        rst        = 1'b1;
        TDC_start  = 1'b0;
        hit_valid  = 1'b0;
        hit_data   = '0;
        hit_int    = '0;
        TDC_Oready = 1'b0;
        TDC_Range  = '0;
        pending    = 1'b0;
        exp_drop   = 1'b0;
        tick();
        tick();
        check_eq("rst_ovalid", 32'(TDC_Ovalid), 32'd0);
        check_eq("rst_odata", 32'(TDC_Odata), 32'd0);
        check_eq("rst_onum", 32'(TDC_Onum), 32'd0);
        check_eq("rst_olast", 32'(TDC_Olast), 32'd0);
        check_eq("rst_drop", 32'(hit_drop), 32'd0);
        rst = 1'b0;
        tick();

        // Two hits, 10-cycle window.
        clear_plan();
        set_limit(10);
        TDC_Range = 15'd160;
        add_hit(2, 15'd300, 4'd5);
        add_hit(5, 15'd120, 4'd2);
        run_frame();

        // Empty window.
        clear_plan();
        set_limit(4);
        run_frame();

        // Overflow: five hits, last on the timeout cycle.
        clear_plan();
        set_limit(6);
        for (int c = 1; c < 6; c++) add_hit(c, 15'(1000 - 100 * c), 4'(c));
        run_frame();

        // Stalled burst.
        clear_plan();
        set_limit(5);
        add_hit(0, 15'd77, 4'd3);
        add_hit(4, 15'd55, 4'd9);
        rdy_pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        run_frame();

        // Start during SEND, then early start in the chained frame, then a third frame.
        clear_plan();
        set_limit(6);
        add_hit(1, 15'd400, 4'd1);
        send_start_obs = 0;
        run_frame();
        check_eq("chain_pending", 32'(pending), 32'd1);
        clear_plan();
        add_hit(3, 15'd900, 4'd4);
        add_hit(1, 15'd800, 4'd6);
        early_at = 3;
        run_frame();
        check_eq("early_pending", 32'(pending), 32'd1);
        clear_plan();
        add_hit(2, 15'd10, 4'd7);
        run_frame();

        // Reset on the second beat of a three-beat burst.
        clear_plan();
        set_limit(5);
        add_hit(0, 15'd11, 4'd1);
        add_hit(1, 15'd22, 4'd2);
        add_hit(2, 15'd33, 4'd3);
        add_hit(3, 15'd44, 4'd4);
        rst_at_obs = 1;
        run_frame();
        check_eq("reset_taken", 32'(did_reset), 32'd1);
        check_eq("mid_rst_ovalid", 32'(TDC_Ovalid), 32'd0);
        check_eq("mid_rst_onum", 32'(TDC_Onum), 32'd0);
        check_eq("mid_rst_olast", 32'(TDC_Olast), 32'd0);
        check_eq("mid_rst_drop", 32'(hit_drop), 32'd0);
        tick();
        check_eq("post_rst_idle", 32'(TDC_Ovalid), 32'd0);
        clear_plan();
        add_hit(1, 15'd555, 4'd8);
        run_frame();

        // Random frames.
        for (int f = 0; f < 40; f++) begin
            clear_plan();
            if (!pending) set_limit($urandom_range(0, 8));
            for (int c = 0; c < ((limit == 0) ? 1 : limit); c++) begin
                if ($urandom_range(0, 9) < 4) add_hit(c, 15'($urandom_range(0, 63)), 4'($urandom));
            end
            if ($urandom_range(0, 4) == 0) early_at = $urandom_range(0, 7);
            if ($urandom_range(0, 3) == 0) send_start_obs = $urandom_range(0, 4);
            rdy_always = 1'b0;
            run_frame();
        end
        while (pending) begin
            clear_plan();
            run_frame();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
